// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for seq_alu and its iterative datapath.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIVU = 4'd12;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift/accumulate datapath shared by MUL (shift-add) and DIVU
// (restoring divide). WIDTH iterations, counter runs WIDTH-1..0.
// hi/lo present the value after the current iteration, so the caller can
// capture the final result on the same edge that retires the last iteration.
// Divider logic is only built when ALU_DIV_EN is defined.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH:0]   sum;

`ifdef ALU_DIV_EN
  logic             mode_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
`else
  logic             unused_mode;
  assign unused_mode = mode;
`endif

  assign done = busy & (cnt == '0);

  // One iteration step: shift-add for MUL, shift-subtract-restore for DIVU.
  always_comb begin
    hi  = hi_q;
    lo  = lo_q;
    sum = '0;
`ifdef ALU_DIV_EN
    rem_sh   = '0;
    rem_diff = '0;
`endif
    if (busy) begin
`ifdef ALU_DIV_EN
      if (mode_q == MODE_DIV) begin
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh[WIDTH-1:0] - opb_q;
        if (rem_sh >= {1'b0, opb_q}) begin
          hi = rem_diff;
          lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi = rem_sh[WIDTH-1:0];
          lo = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        hi  = sum[WIDTH:1];
        lo  = {sum[0], lo_q[WIDTH-2+1:1]};
      end
    end
  end

  // Operand load on start, then one iteration per clock until the counter hits 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
`ifdef ALU_DIV_EN
      mode_q <= MODE_MUL;
`endif
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CNT_W'(WIDTH - 1);
      hi_q  <= '0;
      lo_q  <= a;
      opb_q <= b;
`ifdef ALU_DIV_EN
      mode_q <= mode;
`endif
    end else if (busy) begin
      hi_q <= hi;
      lo_q <= lo;
      cnt  <= cnt - CNT_W'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready on both sides and registered results.
// Single-cycle ops complete the cycle after accept; MUL (and DIVU when the
// ALU_DIV_EN macro is defined) run WIDTH iterations in seq_alu_iter.
// Without ALU_DIV_EN, op 12 is treated as illegal.
//
//  state  | meaning
//  S_IDLE | no result held, ready for a new op
//  S_MUL  | multiply iterating, input stalled
//  S_DIV  | divide iterating, input stalled
//  S_DONE | result held on outputs until consumed
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state;
  logic               accept;
  logic               consume;
  logic               is_mul;
  logic               is_div;
  logic               iter_start;
  logic               iter_busy_unused;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_hi;
  logic [WIDTH-1:0]   iter_lo;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum_ab;
  logic [WIDTH-1:0]   diff_ab;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               sc_ill;

  assign in_ready = ~rst & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  assign is_mul = (op == ALU_MUL);
`ifdef ALU_DIV_EN
  assign is_div = (op == ALU_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign iter_start = accept & (is_mul | is_div);

  assign shamt   = b_in[SHAMT_W-1:0];
  assign sum_ab  = a_in + b_in;
  assign diff_ab = a_in - b_in;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .mode  (is_div ? MODE_DIV : MODE_MUL),
    .a     (a_in),
    .b     (b_in),
    .busy  (iter_busy_unused),
    .done  (iter_done),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  // Single-cycle result and flags, evaluated on the operands being accepted.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (op)
      ALU_ADD: begin
        sc_res = sum_ab;
        sc_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_ab[WIDTH-1] != a_in[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff_ab;
        sc_ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff_ab[WIDTH-1] != a_in[WIDTH-1]);
      end
      ALU_AND:  sc_res = a_in & b_in;
      ALU_OR:   sc_res = a_in | b_in;
      ALU_XOR:  sc_res = a_in ^ b_in;
      ALU_NOR:  sc_res = ~(a_in | b_in);
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
      ALU_SLL:  sc_res = a_in << shamt;
      ALU_SRL:  sc_res = a_in >> shamt;
      ALU_SRA:  sc_res = $unsigned($signed(a_in) >>> shamt);
      ALU_MUL:  sc_res = '0;
`ifdef ALU_DIV_EN
      ALU_DIVU: sc_res = '0;
`endif
      default:  sc_ill = 1'b1;
    endcase
  end

  // Control FSM and output registers; outputs only change on accept, consume or iterator completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= S_MUL;
              out_valid <= 1'b0;
            end else if (is_div) begin
              state     <= S_DIV;
              out_valid <= 1'b0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              result_hi <= '0;
              zero      <= (sc_res == '0);
              overflow  <= sc_ovf;
              illegal   <= sc_ill;
            end
          end else if (consume) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          if (iter_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= iter_lo;
            result_hi <= iter_hi;
            zero      <= (iter_lo == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table plus hand sequences for back-pressure and
// mid-operation reset. Expected results are queued at accept and checked
// whenever out_valid is expected; out_valid/in_ready are predicted each cycle.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         illegal;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         v;
    logic         ill;
    int           lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  vec_t cur;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   acc_flag = 1'b0;

  localparam int LM = W + 1;

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic z, input logic v, input logic i, input int lat);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.res = r; t.hi = h;
    t.z = z; t.v = v; t.ill = i; t.lat = lat;
    return t;
  endfunction

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_p(input string name, input logic [2*W+2:0] act, input logic [2*W+2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got {res,hi,z,v,ill}=%h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: predict and check handshake/outputs, update scoreboard, advance to next negedge.
  task automatic cycle();
    bit ev;
    bit er;
    #1;
    ev = (sb.size() > 0) && ((cyc - sb[0].acc) >= sb[0].v.lat);
    er = !rst && ((sb.size() == 0) || (ev && out_ready));
    chk1("out_valid", out_valid, ev);
    chk1("in_ready", in_ready, er);
    if (ev)
      chk_p("payload", {result, result_hi, zero, overflow, illegal},
            {sb[0].v.res, sb[0].v.hi, sb[0].v.z, sb[0].v.v, sb[0].v.ill});
    if (ev && out_ready) void'(sb.pop_front());
    acc_flag = in_valid && er;
    if (acc_flag) sb.push_back('{cur, cyc});
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    cur = v; op = v.op; a_in = v.a; b_in = v.b; in_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc_flag && n < 100);
    chk1("accept_within_bound", acc_flag, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    chk1("drain_within_bound", sb.size() == 0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a_in = '0; b_in = '0;
    cur = mk(4'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1);

    // Reset state
    @(negedge clk);
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b0);
    chk_p("reset_outputs", {result, result_hi, zero, overflow, illegal}, '0);
    cycle();
    cycle();
    rst = 1'b0;

    // op, a, b, result, result_hi, zero, overflow, illegal, latency
    tbl.push_back(mk(4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1));
    tbl.push_back(mk(4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd5,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd8,  32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd9,  32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd10, 32'h40000000, 32'h00000024, 32'h04000000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1));
    tbl.push_back(mk(4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 1));
    tbl.push_back(mk(4'd15, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 1));
    tbl.push_back(mk(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, LM));
    tbl.push_back(mk(4'd11, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, LM));
    tbl.push_back(mk(4'd11, 32'h00000003, 32'h00000005, 32'h0000000F, 32'h00000000, 1'b0, 1'b0, 1'b0, LM));
    tbl.push_back(mk(4'd0,  32'h00000001, 32'h00000002, 32'h00000003, 32'h0, 1'b0, 1'b0, 1'b0, 1));
`ifdef ALU_DIV_EN
    tbl.push_back(mk(4'd12, 32'd100,      32'd7,        32'd14,         32'd2, 1'b0, 1'b0, 1'b0, LM));
    tbl.push_back(mk(4'd12, 32'd9,        32'd0,        32'hFFFFFFFF,   32'd9, 1'b0, 1'b0, 1'b0, LM));
`else
    tbl.push_back(mk(4'd12, 32'd100,      32'd7,        32'h00000000,   32'h0, 1'b1, 1'b0, 1'b1, 1));
`endif
    tbl.push_back(mk(4'd11, 32'h00000007, 32'h00000006, 32'h0000002A, 32'h00000000, 1'b0, 1'b0, 1'b0, LM));

    foreach (tbl[i]) send(tbl[i]);
    drain();

    // Back-pressure: SRA result held while out_ready is low, next op waits.
    out_ready = 1'b0;
    send(mk(4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    cur = mk(4'd0, 32'h00000001, 32'h00000001, 32'h00000002, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    op = cur.op; a_in = cur.a; b_in = cur.b; in_valid = 1'b1;
    repeat (5) begin
      cycle();
      chk1("held_no_accept", acc_flag, 1'b0);
    end
    out_ready = 1'b1;
    cycle();
    chk1("accept_on_consume", acc_flag, 1'b1);
    drain();

    // Reset 10 cycles into a MUL: no result, outputs cleared immediately.
    send(mk(4'd11, 32'h00000003, 32'h00000007, 32'h00000015, 32'h0, 1'b0, 1'b0, 1'b0, LM));
    in_valid = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    #1;
    chk1("midmul_rst_out_valid", out_valid, 1'b0);
    chk1("midmul_rst_in_ready", in_ready, 1'b0);
    chk_p("midmul_rst_outputs", {result, result_hi, zero, overflow, illegal}, '0);
    sb.delete();
    cycle();
    cycle();
    rst = 1'b0;
    send(mk(4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0, 1));
    drain();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
